// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage pipe: turns hazard, branch and
// data-memory-busy events into per-stage enables, flushes and bubble injection.
module pipe_stall_ctrl #(
    parameter int MAX_STALL    = 15,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             haz_nop,
    input  logic             haz_stall,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_en,
    output logic             stall_ack,
    output logic             stall_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    localparam int              RUN_W      = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_STALL + 1);
    localparam logic [1:0]      FLUSH_INIT = 2'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HAZ   = 2'd1,
        S_MEM   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;
    state_t           eff_state;
    logic [1:0]       flush_left;
    logic [1:0]       flush_left_d;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] run_len_d;
    logic             stall_err_d;
    logic [CNT_W-1:0] stall_cnt_d;

    // Leaving MEM_STALL resumes a pending flush in the same cycle; a resumed
    // hazard stall is treated as a fresh RUN cycle so no ack can fire.
    always_comb begin
        eff_state = state;
        if (state == S_MEM) begin
            eff_state = (flush_left != 2'd0) ? S_FLUSH : S_RUN;
        end
    end

    // State register, flush/run trackers, watchdog and stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_RUN;
            flush_left <= 2'd0;
            run_len    <= '0;
            stall_err  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_d;
            flush_left <= flush_left_d;
            run_len    <= run_len_d;
            stall_err  <= stall_err_d;
            stall_cnt  <= stall_cnt_d;
        end
    end

    // Next-state logic; priority mem_busy > br_taken > flush > haz_stall
    always_comb begin
        state_d      = eff_state;
        flush_left_d = flush_left;
        run_len_d    = run_len;
        if (mem_busy) begin
            state_d = S_MEM;
        end else if (br_taken) begin
            state_d      = (FLUSH_CYCLES > 0) ? S_FLUSH : S_RUN;
            flush_left_d = FLUSH_INIT;
            run_len_d    = '0;
        end else if (eff_state == S_FLUSH) begin
            run_len_d = '0;
            if (flush_left <= 2'd1) begin
                flush_left_d = 2'd0;
                state_d      = haz_stall ? S_HAZ : S_RUN;
            end else begin
                flush_left_d = flush_left - 2'd1;
            end
        end else if (haz_stall) begin
            state_d = S_HAZ;
            if (run_len != RUN_MAX) begin
                run_len_d = run_len + RUN_W'(1);
            end
        end else begin
            state_d   = S_RUN;
            run_len_d = '0;
        end
    end

    always_comb begin
        stall_err_d = stall_err | (run_len_d == RUN_MAX);
        stall_cnt_d = stall_cnt;
        if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt + CNT_W'(1);
        end
    end

    // Output decode; reset values hold the whole pipe and feed NOPs
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        pipe_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        stall_ack   = 1'b0;
        if (rst) begin
            if (mem_busy) begin
                ifid_flush  = 1'b0;
                idex_bubble = 1'b0;
            end else if (br_taken) begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                pipe_en = 1'b1;
            end else if (eff_state == S_FLUSH) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                pipe_en     = 1'b1;
                idex_bubble = 1'b0;
            end else if (haz_stall) begin
                pipe_en    = 1'b1;
                ifid_flush = 1'b0;
            end else begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                pipe_en     = 1'b1;
                ifid_flush  = 1'b0;
                idex_bubble = haz_nop;
                stall_ack   = (eff_state == S_HAZ);
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vectors, a rule-level model checked every
// cycle, plus hand-computed literal expectations along the way.
module tb_pipe_stall_ctrl;

    localparam int MAX_STALL    = 15;
    localparam int FLUSH_CYCLES = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic haz_nop = 1'b0;
    logic haz_stall = 1'b0;
    logic br_taken = 1'b0;
    logic mem_busy = 1'b0;

    logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, stall_ack, stall_err;
    logic [15:0] stall_cnt;
    logic [1:0]  dbg_state;
    logic        pc_en_4, ifid_en_4, ifid_flush_4, idex_bubble_4, pipe_en_4, stall_ack_4, stall_err_4;
    logic [3:0]  stall_cnt_4;
    logic [1:0]  dbg_state_4;

    int errors = 0;
    int checks = 0;
    bit done = 1'b0;

    pipe_stall_ctrl #(.MAX_STALL(MAX_STALL), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .haz_nop(haz_nop), .haz_stall(haz_stall),
        .br_taken(br_taken), .mem_busy(mem_busy), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_en(pipe_en),
        .stall_ack(stall_ack), .stall_err(stall_err), .stall_cnt(stall_cnt),
        .dbg_state(dbg_state)
    );

    pipe_stall_ctrl #(.MAX_STALL(MAX_STALL), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .haz_nop(haz_nop), .haz_stall(haz_stall),
        .br_taken(br_taken), .mem_busy(mem_busy), .pc_en(pc_en_4), .ifid_en(ifid_en_4),
        .ifid_flush(ifid_flush_4), .idex_bubble(idex_bubble_4), .pipe_en(pipe_en_4),
        .stall_ack(stall_ack_4), .stall_err(stall_err_4), .stall_cnt(stall_cnt_4),
        .dbg_state(dbg_state_4)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Model: remaining flush cycles, consecutive stall length, whether the last
    // active cycle was a hazard stall, counters and the watchdog flag.
    int m_fl = 0;
    int m_run = 0;
    int m_cnt = 0;
    int m_cnt4 = 0;
    bit m_hs = 1'b0;
    bit m_err = 1'b0;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic flush;
        logic bub;
        logic pipe;
        logic ack;
    } exp_t;

    exp_t m_e;
    exp_t c_e;

    function automatic exp_t expect_now();
        exp_t e;
        if (!rst) begin
            e.pc = 0; e.ifid = 0; e.pipe = 0; e.flush = 1; e.bub = 1;
        end else if (mem_busy) begin
            e.pc = 0; e.ifid = 0; e.pipe = 0; e.flush = 0; e.bub = 0;
        end else if (br_taken) begin
            e.pc = 1; e.ifid = 1; e.pipe = 1; e.flush = 1; e.bub = 1;
        end else if (m_fl > 0) begin
            e.pc = 1; e.ifid = 1; e.pipe = 1; e.flush = 1; e.bub = 0;
        end else if (haz_stall) begin
            e.pc = 0; e.ifid = 0; e.pipe = 1; e.flush = 0; e.bub = 1;
        end else begin
            e.pc = 1; e.ifid = 1; e.pipe = 1; e.flush = 0; e.bub = haz_nop;
        end
        e.ack = rst && !mem_busy && !br_taken && (m_fl == 0) && m_hs && !haz_stall;
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fl = 0; m_run = 0; m_cnt = 0; m_cnt4 = 0; m_hs = 0; m_err = 0;
        end else begin
            m_e = expect_now();
            if (!m_e.pc) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (mem_busy) begin
                m_hs = 0;
            end else if (br_taken) begin
                m_fl = FLUSH_CYCLES; m_run = 0; m_hs = 0;
            end else if (m_fl > 0) begin
                m_fl--; m_run = 0; m_hs = (m_fl == 0) && haz_stall;
            end else if (haz_stall) begin
                m_hs = 1;
                if (m_run < MAX_STALL + 1) m_run++;
                if (m_run == MAX_STALL + 1) m_err = 1;
            end else begin
                m_hs = 0; m_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare, once per cycle away from the active edge
    always @(negedge clk) begin
        if (!done) begin
            c_e = expect_now();
            check("pc_en", pc_en, c_e.pc);
            check("ifid_en", ifid_en, c_e.ifid);
            check("ifid_flush", ifid_flush, c_e.flush);
            check("idex_bubble", idex_bubble, c_e.bub);
            check("pipe_en", pipe_en, c_e.pipe);
            check("stall_ack", stall_ack, c_e.ack);
            check("stall_err", stall_err, m_err);
            check("stall_cnt", stall_cnt, m_cnt);
            check("pc_en_4", pc_en_4, c_e.pc);
            check("stall_ack_4", stall_ack_4, c_e.ack);
            check("stall_err_4", stall_err_4, m_err);
            check("stall_cnt_4", stall_cnt_4, m_cnt4);
        end
    end

    // Driver tasks
    task automatic drive(input logic n, input logic s, input logic b, input logic m);
        haz_nop = n; haz_stall = s; br_taken = b; mem_busy = m;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {haz_nop, haz_stall, br_taken, mem_busy}
    logic [3:0] vec [14] = '{4'b0100, 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b0001,
                             4'b0100, 4'b0000, 4'b0110, 4'b0001, 4'b0000, 4'b0100, 4'b0000};

    initial begin
        #2;
        check("rst_pc_en", pc_en, 0);
        check("rst_ifid_flush", ifid_flush, 1);
        check("rst_idex_bubble", idex_bubble, 1);
        check("rst_stall_cnt", stall_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check("rel_pc_en", pc_en, 1);
        check("rel_ifid_en", ifid_en, 1);
        check("rel_pipe_en", pipe_en, 1);
        check("rel_ifid_flush", ifid_flush, 0);
        check("rel_idex_bubble", idex_bubble, 0);
        check("rel_stall_err", stall_err, 0);
        step();

        // Three-cycle hazard stall then release
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            check("haz_pc_en", pc_en, 0);
            check("haz_bubble", idex_bubble, 1);
            check("haz_ack", stall_ack, 0);
            step();
        end
        drive(0, 0, 0, 0);
        check("haz_release_ack", stall_ack, 1);
        step();
        check("haz_cnt3", stall_cnt, 3);
        drive(0, 0, 0, 0);
        check("haz_ack_once", stall_ack, 0);
        step();

        // Branch with a concurrent hazard stall
        drive(0, 1, 1, 0);
        check("br_flush", ifid_flush, 1);
        check("br_bubble", idex_bubble, 1);
        check("br_pc_en", pc_en, 1);
        step();
        drive(0, 1, 0, 0);
        check("flush_cyc_flush", ifid_flush, 1);
        check("flush_cyc_bubble", idex_bubble, 0);
        check("flush_cyc_ack", stall_ack, 0);
        step();
        drive(0, 1, 0, 0);
        check("post_flush_stall", pc_en, 0);
        check("post_flush_ack", stall_ack, 0);
        step();
        drive(0, 0, 0, 0);
        check("post_flush_release_ack", stall_ack, 1);
        step();

        // Memory freeze in the middle of a flush
        drive(0, 0, 1, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1);
            check("mem_pc_en", pc_en, 0);
            check("mem_ifid_en", ifid_en, 0);
            check("mem_pipe_en", pipe_en, 0);
            step();
        end
        drive(0, 0, 0, 0);
        check("mem_resume_flush", ifid_flush, 1);
        check("mem_resume_pc_en", pc_en, 1);
        step();
        drive(0, 0, 0, 0);
        check("mem_after_flush", ifid_flush, 0);
        step();
        check("mem_cnt6", stall_cnt, 6);

        // Watchdog: 20 consecutive stalled cycles
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0);
            step();
            check("wd_err_edge", stall_err, (i >= 15) ? 1 : 0);
        end
        drive(0, 0, 0, 0);
        check("wd_release_ack", stall_ack, 1);
        step();
        check("wd_err_sticky", stall_err, 1);
        check("wd_cnt26", stall_cnt, 26);
        check("sat_cnt4", stall_cnt_4, 15);

        // Memory freeze ends a hazard stall without an ack
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
        check("mem_exit_no_ack", stall_ack, 0);
        step();
        drive(1, 0, 0, 0);
        check("nop_pc_en", pc_en, 1);
        check("nop_bubble", idex_bubble, 1);
        check("nop_flush", ifid_flush, 0);
        step();

        for (int i = 0; i < 14; i++) begin
            drive(vec[i][3], vec[i][2], vec[i][1], vec[i][0]);
            step();
        end

        // Asynchronous reset in the middle of a stall
        drive(0, 1, 0, 0);
        step();
        drive(0, 1, 0, 0);
        rst = 1'b0;
        #1;
        check("arst_pc_en", pc_en, 0);
        check("arst_flush", ifid_flush, 1);
        check("arst_bubble", idex_bubble, 1);
        check("arst_ack", stall_ack, 0);
        check("arst_cnt", stall_cnt, 0);
        check("arst_cnt4", stall_cnt_4, 0);
        check("arst_err", stall_err, 0);
        step();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        check("arst_rel_pc_en", pc_en, 1);
        check("arst_rel_flush", ifid_flush, 0);
        check("arst_rel_ack", stall_ack, 0);
        step();

        done = 1'b1;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
